wb_slave_regs: RTL and testbench

WB_SLAVE_REGS -- requirements
Module: wb_slave_regs

---
 rtl/wb_slave_regs.sv | 174 +++++++++++++++++
 tb/tb_wb_slave_regs.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_regs.sv
// wb_slave_regs: Wishbone classic slave, 8-word register file with wait states.
// Define WB_SLV_INTR_EN to turn register 7 into a doorbell driving intr_h.
module wb_slave_regs #(
    parameter int unsigned data_wl  = 16,
    parameter int unsigned adr_wl   = 16,
    parameter int unsigned WAIT_CYC = 2,
    parameter logic [15:0] ID_VAL   = 16'hA5C3
) (
    input  logic               clk,
    input  logic               reset_h,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [adr_wl-1:0]  wb_adr_i,
    input  logic [data_wl-1:0] wb_dat_i,
    output logic [data_wl-1:0] wb_dat_o,
    output logic               wb_ack_o,
    output logic               intr_h,
    input  logic               intr_ack_h
);

    localparam logic [data_wl-1:0] ID_WORD = data_wl'(ID_VAL);
    localparam logic [adr_wl-1:0]  ADR_MAX = adr_wl'(7);
    localparam logic [3:0]         CNT_INIT = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;

    logic [adr_wl-1:0]  r_adr;
    logic               r_we;
    logic [data_wl-1:0] r_wdat;
    logic [data_wl-1:0] r_regs [8];

    logic               r_ack;
    logic [data_wl-1:0] r_dat;

    logic               w_start;
    logic               w_ack_nxt;
    logic [data_wl-1:0] w_dat_nxt;
    logic [adr_wl-1:0]  w_adr_sel;
    logic               w_we_sel;
    logic [2:0]         w_idx;
    logic               w_oor;
    logic [data_wl-1:0] w_rd_word;
    logic               w_commit;

    assign w_start = wb_cyc_i & wb_stb_i;

    always_ff @(posedge clk) begin
        if (reset_h) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_dat   <= w_dat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (WAIT_CYC == 0) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = S_ACK;
                    end
                end
            end
            S_ACK: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // With no wait states the access is acked straight out of IDLE,
    // so the read mux must see the live bus rather than the latch.
    always_comb begin
        w_adr_sel = (r_state == S_IDLE) ? wb_adr_i : r_adr;
        w_we_sel  = (r_state == S_IDLE) ? wb_we_i : r_we;
        w_idx     = w_adr_sel[2:0];
        w_oor     = (w_adr_sel > ADR_MAX);
        if (w_oor) begin
            w_rd_word = '0;
        end else if (w_idx == 3'd0) begin
            w_rd_word = ID_WORD;
        end else begin
            w_rd_word = r_regs[w_idx];
        end
        w_ack_nxt = (w_state_nxt == S_ACK);
        w_dat_nxt = (w_ack_nxt && !w_we_sel) ? w_rd_word : '0;
    end

    always_ff @(posedge clk) begin
        if (reset_h) begin
            r_adr  <= '0;
            r_we   <= 1'b0;
            r_wdat <= '0;
        end else if (r_state == S_IDLE && w_start) begin
            r_adr  <= wb_adr_i;
            r_we   <= wb_we_i;
            r_wdat <= wb_dat_i;
        end
    end

    assign w_commit = (r_state == S_ACK) && r_we &&
                      (r_adr <= ADR_MAX) && (r_adr[2:0] != 3'd0);

    always_ff @(posedge clk) begin
        if (reset_h) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[r_adr[2:0]] <= r_wdat;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;

`ifdef WB_SLV_INTR_EN
    logic r_intr;

    // A doorbell write landing on the same edge as a clear keeps intr_h set.
    always_ff @(posedge clk) begin
        if (reset_h) begin
            r_intr <= 1'b0;
        end else if (w_commit && r_adr[2:0] == 3'd7) begin
            r_intr <= 1'b1;
        end else if (intr_ack_h) begin
            r_intr <= 1'b0;
        end
    end

    assign intr_h = r_intr;
`else
    assign intr_h = 1'b0 & intr_ack_h;
`endif

endmodule

// File: tb/tb_wb_slave_regs.sv
// tb_wb_slave_regs: table vectors, directed corner sequences and random
// accesses checked against a word-level model of the register file.
module tb_wb_slave_regs;

    localparam int W = 2;
`ifdef WB_SLV_INTR_EN
    localparam bit INTR = 1'b1;
`else
    localparam bit INTR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_h = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [15:0] adr = '0;
    logic [15:0] dat_i = '0;
    logic        intr_ack = 1'b0;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        intr_h;

    always #5 clk = ~clk;

    wb_slave_regs #(
        .data_wl(16),
        .adr_wl(16),
        .WAIT_CYC(W),
        .ID_VAL(16'hA5C3)
    ) dut (
        .clk(clk),
        .reset_h(reset_h),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_we_i(we),
        .wb_adr_i(adr),
        .wb_dat_i(dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .intr_h(intr_h),
        .intr_ack_h(intr_ack)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] m_regs [8];
    bit          m_intr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (a >= 16'd8) return 16'h0000;
        if (a == 16'd0) return 16'hA5C3;
        return m_regs[a[2:0]];
    endfunction

    function automatic void m_write(input logic [15:0] a,
                                    input logic [15:0] d);
        if (a < 16'd8 && a != 16'd0) begin
            m_regs[a[2:0]] = d;
            if (a == 16'd7 && INTR) m_intr = 1'b1;
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_intr = 1'b0;
    endfunction

    // data bus must read zero on every cycle without an ack
    always @(negedge clk) begin
        if (!reset_h) begin
            checks++;
            if (!wb_ack_o && wb_dat_o !== 16'h0000) begin
                failures++;
                $display("FAIL dat_idle: got %0h, want 0", wb_dat_o);
            end
        end
    end

    task automatic wait_ack(output int n, output logic [15:0] rd);
        int i = 0;
        n = -1;
        rd = '0;
        while (n < 0 && i < 40) begin
            i++;
            @(posedge clk); #1;
            if (wb_ack_o) begin
                n = i;
                rd = wb_dat_o;
            end
        end
    endtask

    task automatic bus_access(input bit w, input logic [15:0] a,
                              input logic [15:0] d, input bit sync,
                              output logic [15:0] rd, output int lat);
        if (sync) begin
            @(posedge clk); #1;
        end
        cyc = 1'b1;
        stb = 1'b1;
        we = w;
        adr = a;
        dat_i = d;
        wait_ack(lat, rd);
        cyc = 1'b0;
        stb = 1'b0;
        we = 1'b0;
    endtask

    task automatic do_op(input string name, input bit w,
                         input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp);
        logic [15:0] rd;
        int lat;
        bus_access(w, a, d, 1'b1, rd, lat);
        chk({name, "_lat"}, lat, W + 1);
        if (!w) chk({name, "_rd"}, rd, exp);
        if (w) m_write(a, d);
        @(posedge clk); #1;
        chk({name, "_hold_ack"}, wb_ack_o, 1'b0);
        chk({name, "_intr"}, intr_h, m_intr);
    endtask

    typedef struct {
        string       name;
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [15:0] rd;
        logic [15:0] exp;
        int lat;
        int gap;
        int acks;
        bit w;
        logic [15:0] a;
        logic [15:0] d;

        vt[0]  = '{"rst_r5",    1'b0, 16'h0005, 16'h0000, 16'h0000};
        vt[1]  = '{"wr3",       1'b1, 16'h0003, 16'h1234, 16'h0000};
        vt[2]  = '{"rd3",       1'b0, 16'h0003, 16'h0000, 16'h1234};
        vt[3]  = '{"rd_id",     1'b0, 16'h0000, 16'h0000, 16'hA5C3};
        vt[4]  = '{"wr_id",     1'b1, 16'h0000, 16'hFFFF, 16'h0000};
        vt[5]  = '{"rd_id2",    1'b0, 16'h0000, 16'h0000, 16'hA5C3};
        vt[6]  = '{"wr_oor",    1'b1, 16'h0040, 16'hBEEF, 16'h0000};
        vt[7]  = '{"rd_oor",    1'b0, 16'h0040, 16'h0000, 16'h0000};
        vt[8]  = '{"wr_oor3",   1'b1, 16'h004B, 16'h7777, 16'h0000};
        vt[9]  = '{"rd_oor3",   1'b0, 16'h004B, 16'h0000, 16'h0000};
        vt[10] = '{"rd3_keep",  1'b0, 16'h0003, 16'h0000, 16'h1234};
        vt[11] = '{"wr1",       1'b1, 16'h0001, 16'hCAFE, 16'h0000};
        vt[12] = '{"rd1",       1'b0, 16'h0001, 16'h0000, 16'hCAFE};

        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", wb_ack_o, 1'b0);
        chk("rst_dat", wb_dat_o, 16'h0000);
        chk("rst_intr", intr_h, 1'b0);
        reset_h = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_op(vt[i].name, vt[i].w, vt[i].a, vt[i].d, vt[i].exp);
        end

        // doorbell: set, clear, and set colliding with clear
        do_op("wr7", 1'b1, 16'h0007, 16'h0001, 16'h0000);
        chk("intr_set", intr_h, INTR);
        intr_ack = 1'b1;
        @(posedge clk); #1;
        intr_ack = 1'b0;
        m_intr = 1'b0;
        chk("intr_clr", intr_h, 1'b0);
        bus_access(1'b1, 16'h0007, 16'h0002, 1'b1, rd, lat);
        chk("intr_wr_lat", lat, W + 1);
        m_write(16'h0007, 16'h0002);
        chk("intr_at_ack", intr_h, 1'b0);
        intr_ack = 1'b1;
        @(posedge clk); #1;
        intr_ack = 1'b0;
        chk("intr_set_wins", intr_h, INTR);
        intr_ack = 1'b1;
        @(posedge clk); #1;
        intr_ack = 1'b0;
        m_intr = 1'b0;
        chk("intr_clr2", intr_h, 1'b0);
        do_op("rd7", 1'b0, 16'h0007, 16'h0000, 16'h0002);

        // cyc dropped in WAIT: no ack, no write, IDLE on the next cycle
        @(posedge clk); #1;
        cyc = 1'b1;
        stb = 1'b1;
        we = 1'b1;
        adr = 16'h0003;
        dat_i = ~m_read(16'h0003);
        @(posedge clk); #1;
        chk("abort_ack0", wb_ack_o, 1'b0);
        cyc = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack1", wb_ack_o, 1'b0);
        stb = 1'b0;
        we = 1'b0;
        bus_access(1'b0, 16'h0003, 16'h0000, 1'b0, rd, lat);
        chk("abort_lat", lat, W + 1);
        chk("abort_keep", rd, m_read(16'h0003));
        @(posedge clk); #1;

        // reset in WAIT: access abandoned, file cleared
        @(posedge clk); #1;
        cyc = 1'b1;
        stb = 1'b1;
        we = 1'b1;
        adr = 16'h0004;
        dat_i = 16'h5A5A;
        @(posedge clk); #1;
        reset_h = 1'b1;
        cyc = 1'b0;
        stb = 1'b0;
        we = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ack", wb_ack_o, 1'b0);
        chk("rst_mid_dat", wb_dat_o, 16'h0000);
        reset_h = 1'b0;
        m_reset();
        bus_access(1'b0, 16'h0004, 16'h0000, 1'b0, rd, lat);
        chk("rst_mid_lat", lat, W + 1);
        chk("rst_mid_r4", rd, 16'h0000);
        @(posedge clk); #1;
        do_op("rst_r3", 1'b0, 16'h0003, 16'h0000, 16'h0000);
        do_op("b2b_w1", 1'b1, 16'h0001, 16'h1111, 16'h0000);
        do_op("b2b_w3", 1'b1, 16'h0003, 16'h3333, 16'h0000);

        // strobe held across ack with a new address
        @(posedge clk); #1;
        cyc = 1'b1;
        stb = 1'b1;
        we = 1'b0;
        adr = 16'h0001;
        wait_ack(lat, rd);
        chk("b2b_lat1", lat, W + 1);
        chk("b2b_rd1", rd, m_read(16'h0001));
        adr = 16'h0003;
        wait_ack(gap, rd);
        chk("b2b_gap", gap, W + 3);
        chk("b2b_rd2", rd, m_read(16'h0003));
        cyc = 1'b0;
        stb = 1'b0;
        acks = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (wb_ack_o) acks++;
        end
        chk("b2b_extra", acks, 0);

        for (int k = 0; k < 300; k++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) a = 16'($urandom_range(0, 7));
            else a = 16'($urandom_range(8, 65535));
            d = 16'($urandom);
            exp = m_read(a);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if ($urandom_range(0, 7) == 0) begin
                #1;
                intr_ack = 1'b1;
                @(posedge clk); #1;
                intr_ack = 1'b0;
                m_intr = 1'b0;
            end
            do_op("rnd", w, a, d, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
